// File: rtl/brick_pkg.sv
// Shared types for the brick field: 24-bit colour, the 8-entry row palette
// used when BRICK_ROW_COLOR_EN is defined, and the index-width helper.
package brick_pkg;

    typedef logic [23:0] color_t;

    localparam color_t ROW_PALETTE [8] = '{
        24'hFF0000, 24'hFF8000, 24'hFFFF00, 24'h00FF00,
        24'h00FFFF, 24'h0000FF, 24'h8000FF, 24'hFF00FF
    };

    // Width needed to index n items; never below one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/brick_field_if.sv
// Collision-query and field-status bundle between the game logic (master)
// and brick_field (slave).
interface brick_field_if #(
    parameter int NBRICKS = 10
);
    localparam int IDXW = brick_pkg::idx_width(NBRICKS);
    localparam int CNTW = brick_pkg::idx_width(NBRICKS + 1);

    logic            hit_req;
    logic [9:0]      hit_x;
    logic [9:0]      hit_y;
    logic            busy;
    logic            hit_ack;
    logic            hit;
    logic [IDXW-1:0] hit_idx;
    logic            restore;
    logic [CNTW-1:0] remaining;
    logic            level_clear;

    modport master (
        output hit_req, hit_x, hit_y, restore,
        input  busy, hit_ack, hit, hit_idx, remaining, level_clear
    );

    modport slave (
        input  hit_req, hit_x, hit_y, restore,
        output busy, hit_ack, hit, hit_idx, remaining, level_clear
    );
endinterface

// File: rtl/brick_locate.sv
// Combinational point-to-brick mapper: reports whether (px,py) falls inside a
// brick rectangle (gaps excluded) and which row/column it is.
module brick_locate
    import brick_pkg::*;
#(
    parameter int ROWS     = 2,
    parameter int COLS     = 5,
    parameter int BRICK_W  = 124,
    parameter int BRICK_H  = 20,
    parameter int GAP      = 4,
    parameter int ORIGIN_X = 0,
    parameter int ORIGIN_Y = 0,
    parameter int RW       = idx_width(ROWS),
    parameter int CW       = idx_width(COLS)
) (
    input  logic [9:0]    px,
    input  logic [9:0]    py,
    output logic          in_brick,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col
);
    localparam int PITCH_X = BRICK_W + GAP;
    localparam int PITCH_Y = BRICK_H + GAP;

    int   px_i;
    int   py_i;
    logic col_hit_s;
    logic row_hit_s;

    function automatic logic in_span(input int v, input int lo, input int len);
        return (v >= lo) && (v < lo + len);
    endfunction

    assign px_i = int'(px);
    assign py_i = int'(py);

    // Spans never overlap, so OR-ing the matching column number is exact.
    always_comb begin
        col_hit_s = 1'b0;
        col       = '0;
        for (int c = 0; c < COLS; c++) begin
            col_hit_s = col_hit_s | in_span(px_i, ORIGIN_X + c * PITCH_X, BRICK_W);
            col       = col | (in_span(px_i, ORIGIN_X + c * PITCH_X, BRICK_W) ? CW'(c) : CW'(0));
        end
    end

    // Row match, same scheme as the columns.
    always_comb begin
        row_hit_s = 1'b0;
        row       = '0;
        for (int r = 0; r < ROWS; r++) begin
            row_hit_s = row_hit_s | in_span(py_i, ORIGIN_Y + r * PITCH_Y, BRICK_H);
            row       = row | (in_span(py_i, ORIGIN_Y + r * PITCH_Y, BRICK_H) ? RW'(r) : RW'(0));
        end
    end

    assign in_brick = col_hit_s & row_hit_s;

endmodule

// File: rtl/brick_field.sv
// Brick-wall playfield: renders alive bricks and answers ball collision queries.
// Define BRICK_ROW_COLOR_EN to colour each row from the package palette.
module brick_field
    import brick_pkg::*;
#(
    parameter int     ROWS     = 2,
    parameter int     COLS     = 5,
    parameter int     BRICK_W  = 124,
    parameter int     BRICK_H  = 20,
    parameter int     GAP      = 4,
    parameter int     ORIGIN_X = 0,
    parameter int     ORIGIN_Y = 0,
    parameter color_t COLOR    = 24'hFFFFFF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    input  logic          active_pixels,
    output logic [23:0]   vga_color,
    brick_field_if.slave  q
);
    localparam int NB   = ROWS * COLS;
    localparam int IDXW = idx_width(NB);
    localparam int CNTW = idx_width(NB + 1);
    localparam int RW   = idx_width(ROWS);
    localparam int CW   = idx_width(COLS);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [NB-1:0]   alive_r;
    logic [CNTW-1:0] remain_r;
    logic [1:0]      state_r;
    logic [1:0]      state_s;
    logic [9:0]      qx_r;
    logic [9:0]      qy_r;
    logic            busy_r;
    logic            ack_r;
    logic            hit_r;
    logic [IDXW-1:0] idx_r;
    color_t          color_r;

    logic            pix_in_s;
    logic [RW-1:0]   pix_row_s;
    logic [CW-1:0]   pix_col_s;
    logic [IDXW-1:0] pix_idx_s;
    color_t          pix_color_s;
    logic            qry_in_s;
    logic [RW-1:0]   qry_row_s;
    logic [CW-1:0]   qry_col_s;
    logic [IDXW-1:0] qry_idx_s;
    logic            kill_s;

    brick_locate #(
        .ROWS(ROWS), .COLS(COLS), .BRICK_W(BRICK_W), .BRICK_H(BRICK_H), .GAP(GAP),
        .ORIGIN_X(ORIGIN_X), .ORIGIN_Y(ORIGIN_Y), .RW(RW), .CW(CW)
    ) u_pix_locate (
        .px(x), .py(y), .in_brick(pix_in_s), .row(pix_row_s), .col(pix_col_s)
    );

    brick_locate #(
        .ROWS(ROWS), .COLS(COLS), .BRICK_W(BRICK_W), .BRICK_H(BRICK_H), .GAP(GAP),
        .ORIGIN_X(ORIGIN_X), .ORIGIN_Y(ORIGIN_Y), .RW(RW), .CW(CW)
    ) u_qry_locate (
        .px(qx_r), .py(qy_r), .in_brick(qry_in_s), .row(qry_row_s), .col(qry_col_s)
    );

    assign pix_idx_s = IDXW'(int'(pix_row_s) * COLS + int'(pix_col_s));
    assign qry_idx_s = IDXW'(int'(qry_row_s) * COLS + int'(qry_col_s));

`ifdef BRICK_ROW_COLOR_EN
    assign pix_color_s = ROW_PALETTE[3'(pix_row_s)];
`else
    assign pix_color_s = COLOR;
`endif

    // A coincident restore wins over the kill, so the query reports a miss.
    assign kill_s = (state_r == S_LOOKUP) && qry_in_s && alive_r[qry_idx_s] && !q.restore;

    // Query FSM next state; hit_req is only looked at while idle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:   state_s = q.hit_req ? S_LOOKUP : S_IDLE;
            S_LOOKUP: state_s = S_RESP;
            S_RESP:   state_s = S_IDLE;
            default:  state_s = S_IDLE;
        endcase
    end

    // Query sequencing and registered response outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            ack_r   <= 1'b0;
            hit_r   <= 1'b0;
            idx_r   <= '0;
            qx_r    <= 10'd0;
            qy_r    <= 10'd0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != S_IDLE);
            ack_r   <= (state_r == S_LOOKUP);
            hit_r   <= kill_s;
            idx_r   <= kill_s ? qry_idx_s : '0;
            if ((state_r == S_IDLE) && q.hit_req) begin
                qx_r <= q.hit_x;
                qy_r <= q.hit_y;
            end else begin
                qx_r <= qx_r;
                qy_r <= qy_r;
            end
        end
    end

    // Alive bitmap and counter; a kill needs a live bit, so no underflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            alive_r  <= '1;
            remain_r <= CNTW'(NB);
        end else if (q.restore) begin
            alive_r  <= '1;
            remain_r <= CNTW'(NB);
        end else if (kill_s) begin
            alive_r[qry_idx_s] <= 1'b0;
            remain_r           <= remain_r - CNTW'(1);
        end else begin
            alive_r  <= alive_r;
            remain_r <= remain_r;
        end
    end

    // One-cycle pixel pipeline.
    always_ff @(posedge clk) begin
        if (!rst) begin
            color_r <= 24'h000000;
        end else if (active_pixels && pix_in_s && alive_r[pix_idx_s]) begin
            color_r <= pix_color_s;
        end else begin
            color_r <= 24'h000000;
        end
    end

    assign vga_color     = color_r;
    assign q.busy        = busy_r;
    assign q.hit_ack     = ack_r;
    assign q.hit         = hit_r;
    assign q.hit_idx     = idx_r;
    assign q.remaining   = remain_r;
    assign q.level_clear = (remain_r == CNTW'(0));

endmodule

// File: tb/tb_brick_field.sv
// Randomised scoreboard bench for brick_field at default geometry.
module tb_brick_field;
    localparam int ROWS = 2, COLS = 5, NB = 10;
    localparam int BW = 124, BH = 20, PX = 128, PY = 24;

    typedef struct { bit hit; int idx; int rem; longint cyc; } resp_t;
    typedef struct { logic [23:0] col; longint cyc; } pix_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  x = 10'd0, y = 10'd0;
    logic        active_pixels = 1'b0;
    logic [23:0] vga_color;
    longint      cyc = 0;
    int          total = 0, bad = 0;
    bit          alive_m [NB];
    resp_t       exp_q [$];
    pix_t        pix_q [$];

    brick_field_if #(.NBRICKS(NB)) q ();

    brick_field dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .active_pixels(active_pixels),
        .vga_color(vga_color), .q(q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int model_idx(input int px, input int py);
        int c, r;
        c = px / PX;
        r = py / PY;
        if ((px % PX) >= BW || (py % PY) >= BH || c >= COLS || r >= ROWS) return -1;
        return r * COLS + c;
    endfunction

    function automatic int count_alive();
        int n = 0;
        for (int i = 0; i < NB; i++) n += int'(alive_m[i]);
        return n;
    endfunction

    function automatic logic [23:0] exp_color(input int idx);
`ifdef BRICK_ROW_COLOR_EN
        return brick_pkg::ROW_PALETTE[(idx / COLS) % 8];
`else
        return (idx >= 0) ? 24'hFFFFFF : 24'hFFFFFF;
`endif
    endfunction

    task automatic model_restore();
        for (int i = 0; i < NB; i++) alive_m[i] = 1'b1;
    endtask

    // Monitor: compares responses and pixels whenever the DUT presents them.
    always @(posedge clk) begin
        resp_t r;
        #1;
        if (q.hit_ack) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", 64'(q.hit_ack), 64'd0);
            end else begin
                r = exp_q.pop_front();
                chk("ack_cycle", 64'(cyc), 64'(r.cyc));
                chk("hit", 64'(q.hit), 64'(r.hit));
                chk("hit_idx", 64'(q.hit_idx), 64'(r.idx));
                chk("remaining_at_ack", 64'(q.remaining), 64'(r.rem));
            end
        end
        if (pix_q.size() > 0 && pix_q[0].cyc == cyc) begin
            chk("vga_color", 64'(vga_color), 64'(pix_q[0].col));
            void'(pix_q.pop_front());
        end
    end

    task automatic pixel(input int px, input int py, input bit act);
        pix_t p;
        int   idx;
        @(negedge clk);
        x = px[9:0];
        y = py[9:0];
        active_pixels = act;
        idx = model_idx(px, py);
        p.col = (act && idx >= 0 && alive_m[idx]) ? exp_color(idx) : 24'h000000;
        p.cyc = cyc + 1;
        pix_q.push_back(p);
    endtask

    // Issue one query; optionally restore or re-request during LOOKUP.
    task automatic query(input int px, input int py, input bit restore_mid, input bit retrig);
        resp_t r;
        int    idx;
        @(negedge clk);
        q.hit_req = 1'b1;
        q.hit_x = px[9:0];
        q.hit_y = py[9:0];
        idx = model_idx(px, py);
        r.cyc = cyc + 2;
        if (restore_mid) begin
            model_restore();
            r.hit = 1'b0; r.idx = 0;
        end else if (idx >= 0 && alive_m[idx]) begin
            alive_m[idx] = 1'b0;
            r.hit = 1'b1; r.idx = idx;
        end else begin
            r.hit = 1'b0; r.idx = 0;
        end
        r.rem = count_alive();
        exp_q.push_back(r);
        @(negedge clk);
        chk("busy_lookup", 64'(q.busy), 64'd1);
        q.hit_req = retrig;
        q.hit_x = 10'd10;
        q.hit_y = 10'd30;
        q.restore = restore_mid;
        @(negedge clk);
        q.hit_req = 1'b0;
        q.restore = 1'b0;
        repeat (2) @(negedge clk);
        chk("ack_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        chk("busy_idle", 64'(q.busy), 64'd0);
    endtask

    task automatic do_restore();
        @(negedge clk);
        q.restore = 1'b1;
        model_restore();
        @(negedge clk);
        q.restore = 1'b0;
        @(negedge clk);
        chk("restore_remaining", 64'(q.remaining), 64'(count_alive()));
        chk("restore_level_clear", 64'(q.level_clear), 64'd0);
    endtask

    initial begin
        int op;
        q.hit_req = 1'b0; q.hit_x = 10'd0; q.hit_y = 10'd0; q.restore = 1'b0;
        model_restore();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_vga", 64'(vga_color), 64'd0);
        chk("rst_busy", 64'(q.busy), 64'd0);
        chk("rst_ack", 64'(q.hit_ack), 64'd0);
        chk("rst_hit", 64'(q.hit), 64'd0);
        chk("rst_idx", 64'(q.hit_idx), 64'd0);
        chk("rst_remaining", 64'(q.remaining), 64'd10);
        chk("rst_level_clear", 64'(q.level_clear), 64'd0);

        pixel(130, 5, 1'b1);
        pixel(125, 5, 1'b1);
        pixel(5, 44, 1'b1);
        pixel(130, 5, 1'b0);
        pixel(639, 43, 1'b1);
        query(130, 5, 1'b0, 1'b0);
        pixel(130, 5, 1'b1);
        query(130, 5, 1'b0, 1'b0);
        query(600, 300, 1'b0, 1'b0);
        query(260, 30, 1'b0, 1'b1);
        chk("retrig_remaining", 64'(q.remaining), 64'(count_alive()));

        for (int i = 0; i < NB; i++) query((i % COLS) * PX + 60, (i / COLS) * PY + 10, 1'b0, 1'b0);
        chk("clear_remaining", 64'(q.remaining), 64'd0);
        chk("clear_level_clear", 64'(q.level_clear), 64'd1);
        query(60, 10, 1'b0, 1'b0);
        do_restore();

        query(130, 5, 1'b1, 1'b0);
        chk("coincident_remaining", 64'(q.remaining), 64'd10);
        pixel(130, 5, 1'b1);

        @(negedge clk);
        q.hit_req = 1'b1; q.hit_x = 10'd300; q.hit_y = 10'd5;
        @(negedge clk);
        q.hit_req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_restore();
        repeat (3) @(negedge clk);
        chk("midrst_remaining", 64'(q.remaining), 64'd10);
        chk("midrst_busy", 64'(q.busy), 64'd0);

        for (int n = 0; n < 80; n++) begin
            op = int'($urandom_range(0, 9));
            if (op < 5)
                query(int'($urandom_range(0, 700)), int'($urandom_range(0, 60)), 1'b0, 1'($urandom_range(0, 1)));
            else if (op < 9)
                pixel(int'($urandom_range(0, 700)), int'($urandom_range(0, 60)), 1'($urandom_range(0, 1)));
            else
                do_restore();
        end
        repeat (3) @(negedge clk);
        chk("pix_pending", 64'(pix_q.size()), 64'd0);
        chk("final_remaining", 64'(q.remaining), 64'(count_alive()));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/brick_field.md
BRICK_FIELD -- requirements
Module: brick_field

Interface
REQ-001 SHALL have parameter ROWS, default 2, number of brick rows.
REQ-002 SHALL have parameter COLS, default 5, bricks per row.
REQ-003 SHALL have parameters BRICK_W=124, BRICK_H=20, GAP=4, ORIGIN_X=0, ORIGIN_Y=0; brick pitch is BRICK_W+GAP horizontally and BRICK_H+GAP vertically.
REQ-004 SHALL have parameter COLOR, default 24'hFFFFFF, the brick colour.
REQ-005 SHALL have port clk, input, 1, the single system clock.
REQ-006 SHALL have port rst, input, 1, a synchronous, active-low reset.
REQ-007 SHALL have ports x, y, input, 10 each, the current pixel coordinate.
REQ-008 SHALL have port active_pixels, input, 1, high inside the visible area.
REQ-009 SHALL have port vga_color, output, 24, the registered pixel colour.
REQ-010 SHALL have port hit_req, input, 1, a one-cycle collision-query strobe.
REQ-011 SHALL have ports hit_x, hit_y, input, 10 each, the ball probe point, sampled on hit_req.
REQ-012 SHALL have port busy, output, 1, high while a query is in flight.
REQ-013 SHALL have port hit_ack, output, 1, a one-cycle completion pulse.
REQ-014 SHALL have port hit, output, 1, valid with hit_ack: an alive brick was struck.
REQ-015 SHALL have port hit_idx, output, IDXW = clog2(ROWS*COLS), the struck brick index (row*COLS+col), valid with hit_ack.
REQ-016 SHALL have port restore, input, 1, a one-cycle strobe that refills the field.
REQ-017 SHALL have port remaining, output, clog2(ROWS*COLS+1), the count of alive bricks.
REQ-018 SHALL have port level_clear, output, 1, high when remaining==0.

Function
REQ-019 SHALL hold an internal alive bitmap of ROWS*COLS flops; brick (r,c) occupies x in [ORIGIN_X+c*pitch, +BRICK_W) and y in [ORIGIN_Y+r*pitch, +BRICK_H).
REQ-020 SHALL treat gap pixels and coordinates below the origin or beyond the last row or column as outside every brick.
REQ-021 SHALL drive vga_color one clock after x/y: COLOR if active_pixels and the pixel lies in an alive brick, else 0.
REQ-022 SHALL run the query FSM IDLE -> LOOKUP -> RESP -> IDLE, with hit_req accepted only in IDLE.
REQ-023 SHALL register hit_x/hit_y on acceptance, resolve the brick index in LOOKUP, and pulse hit_ack in RESP, two cycles after hit_req.
REQ-024 SHALL set hit=1 only if the probe lies in a brick whose alive bit is 1; it then clears that bit and decrements remaining in the RESP cycle.
REQ-025 SHALL give hit=0 and hit_idx=0 on a miss or on a dead brick, leaving state unchanged.
REQ-026 SHALL ignore hit_req while busy (LOOKUP or RESP); no queueing.
REQ-027 SHALL give restore priority over a coincident kill: all bits go to 1 and remaining goes to ROWS*COLS; the in-flight query still acks, with hit=0.
REQ-028 SHALL never let remaining underflow; a kill is impossible at 0 because no bit is alive.
REQ-029 SHALL assert level_clear combinationally from remaining.

Reset
REQ-030 SHALL, on rst low at a clk edge, set all alive bits to 1, remaining=ROWS*COLS, FSM=IDLE, and busy=0, hit_ack=0, hit=0, hit_idx=0, vga_color=0.
REQ-031 SHALL abort any in-flight query on reset mid-operation, with no hit_ack.

Configuration
REQ-032 SHALL, with BRICK_ROW_COLOR_EN defined, colour row r with package palette entry r mod 8, ignoring COLOR.
REQ-033 SHALL, without BRICK_ROW_COLOR_EN, use COLOR for every brick.

Structure
REQ-034 SHALL place the colour typedef (24-bit), the 8-entry row palette and the index-width helper in package brick_pkg.
REQ-035 SHALL use one sub-module, brick_locate (combinational x,y -> in_brick,row,col), instantiated twice: once for the pixel path and once for the query path.

Verification
REQ-036 SHALL cover reset then a raster scan at defaults: pixel (130,5) -> FFFFFF; (125,5), a gap pixel -> 0; (5,44) -> 0.
REQ-037 SHALL cover a query at (130,5) -> hit_ack 2 cycles later, hit=1, hit_idx=1, remaining 10->9; pixel (130,5) then renders 0.
REQ-038 SHALL cover a repeat query at (130,5) -> hit=0, remaining stays 9; a query at (600,300) -> hit=0.
REQ-039 SHALL cover a hit_req re-asserted during LOOKUP -> ignored, exactly one hit_ack.
REQ-040 SHALL cover killing all 10 bricks -> level_clear=1; restore -> remaining=10, level_clear=0.
REQ-041 SHALL cover restore coincident with a RESP kill -> hit=0, remaining=10, and rst low mid-query -> no hit_ack.
